video_timing_ctrl: RTL and testbench

Run/mode controller for `video_sync_generator`. It owns the generator's `enable` and the active timing parameter set. It accepts new video modes from a host over a valid/ready handshake and validates them. A valid mode is applied only at a frame boundary, with a short generator stop/restart, so no partial or torn frame is ever produced.

---
 rtl/video_timing_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// Run/mode controller for video_sync_generator: owns the generator enable and
// the active timing set, applying validated host modes only at frame boundaries.
module video_timing_ctrl #(
  parameter int HW           = 12,
  parameter int VW           = 11,
  parameter int RESTART_GAP  = 4,
  parameter int DEF_H_TOTAL  = 1040,
  parameter int DEF_H_ACTIVE = 800,
  parameter int DEF_H_SYNC   = 120,
  parameter int DEF_H_BP     = 64,
  parameter int DEF_V_TOTAL  = 666,
  parameter int DEF_V_ACTIVE = 600,
  parameter int DEF_V_SYNC   = 6,
  parameter int DEF_V_BP     = 23
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          run,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [HW-1:0] cfg_h_total,
  input  logic [HW-1:0] cfg_h_active,
  input  logic [HW-1:0] cfg_h_sync,
  input  logic [HW-1:0] cfg_h_bp,
  input  logic [VW-1:0] cfg_v_total,
  input  logic [VW-1:0] cfg_v_active,
  input  logic [VW-1:0] cfg_v_sync,
  input  logic [VW-1:0] cfg_v_bp,
  input  logic          frame_end,
  output logic          gen_enable,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [HW-1:0] h_sync,
  output logic [HW-1:0] h_bp,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic [VW-1:0] v_sync,
  output logic [VW-1:0] v_bp,
  output logic          mode_applied,
  output logic          cfg_err,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshake: a mode transfers on any rising edge where cfg_valid and
  // cfg_ready are both high; the host holds cfg_valid and the fields stable
  // until then.

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PENDING = 3'd2,
    ST_RELOAD  = 3'd3,
    ST_RESTART = 3'd4
  } state_e;

  // RELOAD itself is the first low cycle, so RESTART covers the remaining GAP-1.
  localparam int          GAP_LOAD_I = (RESTART_GAP > 1) ? (RESTART_GAP - 2) : 0;
  localparam logic [3:0]  GAP_LOAD   = 4'(GAP_LOAD_I);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          gen_enable_q;
  logic          cfg_ready_q;
  logic          busy_q;
  logic          mode_applied_q;
  logic          cfg_err_q;

  logic [HW-1:0] act_h_total_q, act_h_active_q, act_h_sync_q, act_h_bp_q;
  logic [VW-1:0] act_v_total_q, act_v_active_q, act_v_sync_q, act_v_bp_q;
  logic [HW-1:0] shd_h_total_q, shd_h_active_q, shd_h_sync_q, shd_h_bp_q;
  logic [VW-1:0] shd_v_total_q, shd_v_active_q, shd_v_sync_q, shd_v_bp_q;

  logic          cfg_hs;
  logic [HW+1:0] h_sum;
  logic [VW+1:0] v_sum;
  logic          h_ok;
  logic          v_ok;
  logic          cfg_ok;

  assign cfg_hs = cfg_valid & cfg_ready_q;

  // Sums carry two spare bits so three max-width terms cannot wrap.
  assign h_sum = {2'b00, cfg_h_sync} + {2'b00, cfg_h_bp} + {2'b00, cfg_h_active};
  assign v_sum = {2'b00, cfg_v_sync} + {2'b00, cfg_v_bp} + {2'b00, cfg_v_active};

  assign h_ok = (cfg_h_sync != '0) && (cfg_h_active != '0) && (cfg_h_bp != '0) &&
                (h_sum < {2'b00, cfg_h_total}) && (cfg_h_total >= HW'(16));
  assign v_ok = (cfg_v_sync != '0) && (cfg_v_active != '0) && (cfg_v_bp != '0) &&
                (v_sum < {2'b00, cfg_v_total}) && (cfg_v_total >= VW'(4));
  assign cfg_ok = h_ok & v_ok;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= ST_STOPPED;
      cnt_q          <= '0;
      gen_enable_q   <= 1'b0;
      cfg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      mode_applied_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      act_h_total_q  <= HW'(DEF_H_TOTAL);
      act_h_active_q <= HW'(DEF_H_ACTIVE);
      act_h_sync_q   <= HW'(DEF_H_SYNC);
      act_h_bp_q     <= HW'(DEF_H_BP);
      act_v_total_q  <= VW'(DEF_V_TOTAL);
      act_v_active_q <= VW'(DEF_V_ACTIVE);
      act_v_sync_q   <= VW'(DEF_V_SYNC);
      act_v_bp_q     <= VW'(DEF_V_BP);
      shd_h_total_q  <= HW'(DEF_H_TOTAL);
      shd_h_active_q <= HW'(DEF_H_ACTIVE);
      shd_h_sync_q   <= HW'(DEF_H_SYNC);
      shd_h_bp_q     <= HW'(DEF_H_BP);
      shd_v_total_q  <= VW'(DEF_V_TOTAL);
      shd_v_active_q <= VW'(DEF_V_ACTIVE);
      shd_v_sync_q   <= VW'(DEF_V_SYNC);
      shd_v_bp_q     <= VW'(DEF_V_BP);
    end else begin
      mode_applied_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      unique case (state_q)
        ST_STOPPED: begin
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cfg_hs) begin
            if (cfg_ok) begin
              shd_h_total_q  <= cfg_h_total;
              shd_h_active_q <= cfg_h_active;
              shd_h_sync_q   <= cfg_h_sync;
              shd_h_bp_q     <= cfg_h_bp;
              shd_v_total_q  <= cfg_v_total;
              shd_v_active_q <= cfg_v_active;
              shd_v_sync_q   <= cfg_v_sync;
              shd_v_bp_q     <= cfg_v_bp;
              act_h_total_q  <= cfg_h_total;
              act_h_active_q <= cfg_h_active;
              act_h_sync_q   <= cfg_h_sync;
              act_h_bp_q     <= cfg_h_bp;
              act_v_total_q  <= cfg_v_total;
              act_v_active_q <= cfg_v_active;
              act_v_sync_q   <= cfg_v_sync;
              act_v_bp_q     <= cfg_v_bp;
              mode_applied_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (run) begin
            state_q      <= ST_RUNNING;
            gen_enable_q <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (cfg_hs && !cfg_ok) begin
            cfg_err_q <= 1'b1;
          end
          // An accepted mode wins over a coincident frame_end: it waits for the next one.
          if (cfg_hs && cfg_ok) begin
            shd_h_total_q  <= cfg_h_total;
            shd_h_active_q <= cfg_h_active;
            shd_h_sync_q   <= cfg_h_sync;
            shd_h_bp_q     <= cfg_h_bp;
            shd_v_total_q  <= cfg_v_total;
            shd_v_active_q <= cfg_v_active;
            shd_v_sync_q   <= cfg_v_sync;
            shd_v_bp_q     <= cfg_v_bp;
            state_q        <= ST_PENDING;
            cfg_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
          end else if (!run && frame_end) begin
            state_q      <= ST_STOPPED;
            gen_enable_q <= 1'b0;
          end
        end

        ST_PENDING: begin
          if (frame_end) begin
            gen_enable_q   <= 1'b0;
            act_h_total_q  <= shd_h_total_q;
            act_h_active_q <= shd_h_active_q;
            act_h_sync_q   <= shd_h_sync_q;
            act_h_bp_q     <= shd_h_bp_q;
            act_v_total_q  <= shd_v_total_q;
            act_v_active_q <= shd_v_active_q;
            act_v_sync_q   <= shd_v_sync_q;
            act_v_bp_q     <= shd_v_bp_q;
            mode_applied_q <= 1'b1;
            if (run) begin
              state_q <= ST_RELOAD;
            end else begin
              state_q     <= ST_STOPPED;
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end

        ST_RELOAD: begin
          if (RESTART_GAP <= 1) begin
            state_q      <= run ? ST_RUNNING : ST_STOPPED;
            gen_enable_q <= run;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            state_q <= ST_RESTART;
            cnt_q   <= GAP_LOAD;
          end
        end

        ST_RESTART: begin
          if (cnt_q == '0) begin
            state_q      <= run ? ST_RUNNING : ST_STOPPED;
            gen_enable_q <= run;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: begin
          state_q      <= ST_STOPPED;
          gen_enable_q <= 1'b0;
          cfg_ready_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign gen_enable   = gen_enable_q;
  assign busy         = busy_q;
  assign mode_applied = mode_applied_q;
  assign cfg_err      = cfg_err_q;
  assign dbg_state    = state_q;

  assign h_total  = act_h_total_q;
  assign h_active = act_h_active_q;
  assign h_sync   = act_h_sync_q;
  assign h_bp     = act_h_bp_q;
  assign v_total  = act_v_total_q;
  assign v_active = act_v_active_q;
  assign v_sync   = act_v_sync_q;
  assign v_bp     = act_v_bp_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl: directed mode loads, stop/restart
// timing and reset recovery, with applied modes checked against an expected queue.
module tb_video_timing_ctrl;

  localparam int HW  = 12;
  localparam int VW  = 11;
  localparam int GAP = 4;
  localparam int MW  = 4 * HW + 4 * VW;

  localparam logic [2:0] S_STOPPED = 3'd0;
  localparam logic [2:0] S_RUNNING = 3'd1;
  localparam logic [2:0] S_PENDING = 3'd2;
  localparam logic [2:0] S_RELOAD  = 3'd3;

  localparam logic [MW-1:0] M_DEF  = {12'd1040, 12'd800, 12'd120, 12'd64, 11'd666, 11'd600, 11'd6, 11'd23};
  localparam logic [MW-1:0] M_480  = {12'd858, 12'd720, 12'd62, 12'd60, 11'd525, 11'd480, 11'd6, 11'd30};
  localparam logic [MW-1:0] M_720  = {12'd1650, 12'd1280, 12'd40, 12'd220, 11'd750, 11'd720, 11'd5, 11'd20};
  localparam logic [MW-1:0] M_BAD  = {12'd800, 12'd800, 12'd40, 12'd220, 11'd750, 11'd720, 11'd5, 11'd20};
  localparam logic [MW-1:0] M_EQ   = {12'd1000, 12'd800, 12'd100, 12'd100, 11'd666, 11'd600, 11'd6, 11'd23};
  localparam logic [MW-1:0] M_EDGE = {12'd1000, 12'd800, 12'd100, 12'd99, 11'd666, 11'd600, 11'd6, 11'd23};
  localparam logic [MW-1:0] M_1080 = {12'd2200, 12'd1920, 12'd44, 12'd148, 11'd1125, 11'd1080, 11'd5, 11'd36};
  localparam logic [MW-1:0] M_LOST = {12'd900, 12'd640, 12'd96, 12'd48, 11'd525, 11'd480, 11'd2, 11'd33};

  logic          pclk;
  logic          rst;
  logic          run;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [HW-1:0] cfg_h_total, cfg_h_active, cfg_h_sync, cfg_h_bp;
  logic [VW-1:0] cfg_v_total, cfg_v_active, cfg_v_sync, cfg_v_bp;
  logic          frame_end;
  logic          gen_enable;
  logic [HW-1:0] h_total, h_active, h_sync, h_bp;
  logic [VW-1:0] v_total, v_active, v_sync, v_bp;
  logic          mode_applied;
  logic          cfg_err;
  logic          busy;
  logic [2:0]    dbg_state;

  logic [MW-1:0] exp_q[$];
  int            chk_cnt  = 0;
  int            pass_cnt = 0;

  video_timing_ctrl #(.HW(HW), .VW(VW), .RESTART_GAP(GAP)) dut (
    .pclk(pclk), .rst(rst), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_active(cfg_h_active),
    .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_total(cfg_v_total), .cfg_v_active(cfg_v_active),
    .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .frame_end(frame_end), .gen_enable(gen_enable),
    .h_total(h_total), .h_active(h_active), .h_sync(h_sync), .h_bp(h_bp),
    .v_total(v_total), .v_active(v_active), .v_sync(v_sync), .v_bp(v_bp),
    .mode_applied(mode_applied), .cfg_err(cfg_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Checker
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [MW-1:0] obs_mode();
    return {h_total, h_active, h_sync, h_bp, v_total, v_active, v_sync, v_bp};
  endfunction

  // Scoreboard: every mode_applied pulse must match the oldest expected mode.
  always @(negedge pclk) begin
    if (mode_applied) begin
      if (exp_q.size() == 0) begin
        check("unexpected_apply", 96'(obs_mode()), 96'(0));
      end else begin
        logic [MW-1:0] e;
        e = exp_q.pop_front();
        check("applied_mode", 96'(obs_mode()), 96'(e));
      end
    end
  end

  // Drivers
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_mode(input logic [MW-1:0] m);
    {cfg_h_total, cfg_h_active, cfg_h_sync, cfg_h_bp,
     cfg_v_total, cfg_v_active, cfg_v_sync, cfg_v_bp} = m;
  endtask

  // Presents a mode, waits (bounded) for ready, and returns one cycle after the handshake edge.
  task automatic send_cfg(input logic [MW-1:0] m, input bit expect_apply);
    int n;
    set_mode(m);
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("cfg_ready_timeout", 96'(0), 96'(1));
    if (expect_apply) exp_q.push_back(m);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  initial begin
    int low;
    int ready_hi;
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; frame_end = 1'b0;
    set_mode(M_DEF);
    repeat (3) tick();

    check("rst_gen_enable", 96'(gen_enable), 96'(0));
    check("rst_cfg_ready", 96'(cfg_ready), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_mode_applied", 96'(mode_applied), 96'(0));
    check("rst_cfg_err", 96'(cfg_err), 96'(0));
    check("rst_mode", 96'(obs_mode()), 96'(M_DEF));

    // Reset release, then run
    rst = 1'b0;
    tick();
    check("stopped_ready", 96'(cfg_ready), 96'(1));
    check("stopped_gen", 96'(gen_enable), 96'(0));
    run = 1'b1;
    tick();
    check("run_gen_enable", 96'(gen_enable), 96'(1));
    check("run_state", 96'(dbg_state), 96'(S_RUNNING));
    check("run_def_mode", 96'(obs_mode()), 96'(M_DEF));
    check("run_ready", 96'(cfg_ready), 96'(1));

    // Stop without a pending mode
    run = 1'b0;
    repeat ($urandom_range(2, 6)) tick();
    check("stop_wait_gen", 96'(gen_enable), 96'(1));
    pulse_frame_end();
    check("stop_gen", 96'(gen_enable), 96'(0));
    check("stop_state", 96'(dbg_state), 96'(S_STOPPED));

    // Direct load while stopped
    send_cfg(M_480, 1'b1);
    check("stopped_apply_pulse", 96'(mode_applied), 96'(1));
    check("stopped_apply_mode", 96'(obs_mode()), 96'(M_480));
    check("stopped_apply_gen", 96'(gen_enable), 96'(0));
    check("stopped_apply_state", 96'(dbg_state), 96'(S_STOPPED));
    tick();
    check("stopped_apply_once", 96'(mode_applied), 96'(0));

    // Running load with frame-boundary reload
    run = 1'b1;
    tick();
    check("rerun_gen", 96'(gen_enable), 96'(1));
    send_cfg(M_720, 1'b1);
    check("pending_ready", 96'(cfg_ready), 96'(0));
    check("pending_busy", 96'(busy), 96'(1));
    check("pending_state", 96'(dbg_state), 96'(S_PENDING));
    ready_hi = 0;
    repeat (200) begin
      tick();
      if (cfg_ready || !gen_enable) ready_hi++;
    end
    check("pending_hold", 96'(ready_hi), 96'(0));
    check("pending_mode_held", 96'(obs_mode()), 96'(M_480));
    pulse_frame_end();
    check("reload_gen", 96'(gen_enable), 96'(0));
    check("reload_pulse", 96'(mode_applied), 96'(1));
    check("reload_mode", 96'(obs_mode()), 96'(M_720));
    check("reload_state", 96'(dbg_state), 96'(S_RELOAD));
    low = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gen_enable) break;
      low++;
    end
    check("restart_gap", 96'(low), 96'(GAP));
    check("restart_ready", 96'(cfg_ready), 96'(1));
    check("restart_busy", 96'(busy), 96'(0));
    check("restart_state", 96'(dbg_state), 96'(S_RUNNING));

    // Rejected modes while running
    send_cfg(M_BAD, 1'b0);
    check("bad_err", 96'(cfg_err), 96'(1));
    check("bad_state", 96'(dbg_state), 96'(S_RUNNING));
    check("bad_ready", 96'(cfg_ready), 96'(1));
    check("bad_mode", 96'(obs_mode()), 96'(M_720));
    tick();
    check("bad_err_once", 96'(cfg_err), 96'(0));
    send_cfg(M_EQ, 1'b0);
    check("sum_eq_total_err", 96'(cfg_err), 96'(1));
    check("sum_eq_total_state", 96'(dbg_state), 96'(S_RUNNING));

    // Handshake coincident with frame_end, then stop with the mode pending
    frame_end = 1'b1;
    send_cfg(M_EDGE, 1'b1);
    frame_end = 1'b0;
    check("coincident_state", 96'(dbg_state), 96'(S_PENDING));
    check("coincident_err", 96'(cfg_err), 96'(0));
    check("coincident_no_apply", 96'(mode_applied), 96'(0));
    check("coincident_mode", 96'(obs_mode()), 96'(M_720));
    run = 1'b0;
    repeat ($urandom_range(3, 8)) tick();
    check("stop_pending_gen", 96'(gen_enable), 96'(1));
    pulse_frame_end();
    check("stop_pending_gen_off", 96'(gen_enable), 96'(0));
    check("stop_pending_pulse", 96'(mode_applied), 96'(1));
    check("stop_pending_mode", 96'(obs_mode()), 96'(M_EDGE));
    check("stop_pending_state", 96'(dbg_state), 96'(S_STOPPED));
    tick();
    pulse_frame_end();
    check("second_fe_gen", 96'(gen_enable), 96'(0));
    check("second_fe_pulse", 96'(mode_applied), 96'(0));
    check("second_fe_state", 96'(dbg_state), 96'(S_STOPPED));

    // Reset in the middle of RESTART
    run = 1'b1;
    tick();
    send_cfg(M_1080, 1'b1);
    pulse_frame_end();
    tick();
    rst = 1'b1;
    tick();
    check("rst_restart_gen", 96'(gen_enable), 96'(0));
    check("rst_restart_busy", 96'(busy), 96'(0));
    check("rst_restart_mode", 96'(obs_mode()), 96'(M_DEF));
    rst = 1'b0;
    tick();
    check("post_rst_run", 96'(gen_enable), 96'(1));

    // Reset while a mode is pending: the shadow must be discarded
    send_cfg(M_LOST, 1'b0);
    check("lost_pending", 96'(dbg_state), 96'(S_PENDING));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse_frame_end();
    check("lost_no_apply", 96'(mode_applied), 96'(0));
    check("lost_mode", 96'(obs_mode()), 96'(M_DEF));
    check("lost_state", 96'(dbg_state), 96'(S_RUNNING));
    repeat (3) tick();

    check("exp_q_empty", 96'(exp_q.size()), 96'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
